// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite line engine: slot record, FSM states,
// sprite size and default register map.
package sprite_pkg;

  localparam int unsigned SPR_SIZE      = 16;
  localparam logic [15:0] DEF_XY_BASE   = 16'h5060;
  localparam logic [15:0] DEF_ATTR_BASE = 16'h4FF0;
  localparam logic [15:0] DEF_FLIP_ADDR = 16'h5003;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StFetch,
    StDraw
  } spr_state_e;

  typedef struct packed {
    logic [7:0] sx;
    logic [3:0] prow;
    logic [5:0] num;
    logic       xflip;
    logic [5:0] pal;
  } spr_slot_t;

endpackage

// File: rtl/sprite_line_buffer.sv
// Ping-pong scanline buffer: the back half takes render writes, the front half is
// read and cleared by the display side one pixel per cycle.
module sprite_line_buffer #(
  parameter int unsigned LINE_W = 224
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       swap,
  input  logic       we,
  input  logic [7:0] waddr,
  input  logic [7:0] wdata,
  input  logic       re,
  input  logic [7:0] raddr,
  output logic [7:0] rdata
);

  logic [7:0] mem_q [2][LINE_W];
  logic       sel_q;
  logic [7:0] rdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q   <= 1'b0;
      rdata_q <= '0;
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < LINE_W; i++) begin
          mem_q[b][i] <= '0;
        end
      end
    end else begin
      if (swap) sel_q <= ~sel_q;
      rdata_q <= '0;
      if (we) mem_q[~sel_q][waddr] <= wdata;
      // Read-and-clear leaves the front half blank for its next turn as back buffer.
      if (re && ({1'b0, raddr} < 9'(LINE_W))) begin
        rdata_q             <= mem_q[sel_q][raddr];
        mem_q[sel_q][raddr] <= '0;
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sprite_line_engine.sv
// Scans sprite attributes for the next scanline, fetches 2bpp pattern bytes and
// composites them into a line buffer. Define SPRITE_REMAP_EN to remap native coordinates.
module sprite_line_engine
  import sprite_pkg::*;
#(
  parameter int unsigned NUM_SPRITES  = 8,
  parameter int unsigned MAX_PER_LINE = 8,
  parameter int unsigned LINE_W       = 224,
  parameter logic [15:0] XY_BASE      = DEF_XY_BASE,
  parameter logic [15:0] ATTR_BASE    = DEF_ATTR_BASE,
  parameter logic [15:0] FLIP_ADDR    = DEF_FLIP_ADDR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [15:0] wr_addr,
  input  logic [7:0]  wr_data,
  input  logic        line_start,
  input  logic [8:0]  next_row,
  input  logic        disp_en,
  input  logic [7:0]  col,
  output logic [11:0] rom_addr,
  input  logic [7:0]  rom_data,
  output logic        spr_valid,
  output logic [1:0]  spr_pix,
  output logic [5:0]  spr_pal,
  output logic        busy,
  output logic        overflow,
  output logic        late
);

  localparam int unsigned IdxW  = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
  localparam int unsigned SlotW = (MAX_PER_LINE > 1) ? $clog2(MAX_PER_LINE) : 1;
  localparam int unsigned CntW  = $clog2(MAX_PER_LINE + 1);

  logic [7:0] x_q    [NUM_SPRITES];
  logic [7:0] y_q    [NUM_SPRITES];
  logic [7:0] attr_q [NUM_SPRITES];
  logic [5:0] pal_q  [NUM_SPRITES];
  logic       flip_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        x_q[i]    <= '0;
        y_q[i]    <= '0;
        attr_q[i] <= '0;
        pal_q[i]  <= '0;
      end
      flip_q <= 1'b0;
    end else if (wr_en) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        if (wr_addr == XY_BASE + 16'(2 * i))       x_q[i]    <= wr_data;
        if (wr_addr == XY_BASE + 16'(2 * i + 1))   y_q[i]    <= wr_data;
        if (wr_addr == ATTR_BASE + 16'(2 * i))     attr_q[i] <= wr_data;
        if (wr_addr == ATTR_BASE + 16'(2 * i + 1)) pal_q[i]  <= wr_data[5:0];
      end
      if (wr_addr == FLIP_ADDR) flip_q <= wr_data[0];
    end
  end

  spr_state_e       state_q, state_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [SlotW-1:0] cur_q, cur_d;
  logic [1:0]       grp_q, grp_d, k_q, k_d;
  logic             ovf_q, ovf_d, late_q, late_d;
  logic [7:0]       row_q, row_d;
  spr_slot_t        slot_q [MAX_PER_LINE];

  logic [7:0] scan_sx, scan_sy, scan_d;
  logic       scan_hit, slot_we, buf_we, swap;
  spr_slot_t  scan_slot, cur_slot;
  logic [3:0] pix_c;
  logic [8:0] pix_x;
  logic [1:0] pix_code;
  logic [7:0] buf_rdata;
  logic       unused_row_msb;

  assign unused_row_msb = next_row[8];

  always_comb begin
`ifdef SPRITE_REMAP_EN
    scan_sx = 8'd240 - x_q[idx_q];
    scan_sy = 8'd15 - y_q[idx_q];
`else
    scan_sx = x_q[idx_q];
    scan_sy = y_q[idx_q];
`endif
    scan_d          = row_q - scan_sy;
    scan_hit        = scan_d < 8'(SPR_SIZE);
    scan_slot.sx    = scan_sx;
    scan_slot.prow  = scan_d[3:0] ^ {4{attr_q[idx_q][0] ^ flip_q}};
    scan_slot.num   = attr_q[idx_q][7:2];
    scan_slot.xflip = attr_q[idx_q][1] ^ flip_q;
    scan_slot.pal   = pal_q[idx_q];
  end

  assign cur_slot = slot_q[cur_q];
  assign pix_c    = {grp_q, k_q} ^ {4{cur_slot.xflip}};
  assign pix_x    = {1'b0, cur_slot.sx} + {5'b0, pix_c};
  assign pix_code = rom_data[{k_q, 1'b0} +: 2];
  assign rom_addr = {cur_slot.num, cur_slot.prow, grp_q};

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    cur_d   = cur_q;
    grp_d   = grp_q;
    k_d     = k_q;
    ovf_d   = ovf_q;
    row_d   = row_q;
    slot_we = 1'b0;
    buf_we  = 1'b0;
    swap    = 1'b0;
    late_d  = 1'b0;
    // A new line always wins; an unfinished render is abandoned in place.
    if (line_start) begin
      swap    = 1'b1;
      late_d  = (state_q != StIdle);
      ovf_d   = 1'b0;
      cnt_d   = '0;
      idx_d   = '0;
      row_d   = next_row[7:0];
      state_d = StScan;
    end else begin
      case (state_q)
        StScan: begin
          if (scan_hit) begin
            if (cnt_q < CntW'(MAX_PER_LINE)) begin
              slot_we = 1'b1;
              cnt_d   = cnt_q + CntW'(1);
            end else begin
              ovf_d = 1'b1;
            end
          end
          if (idx_q == IdxW'(NUM_SPRITES - 1)) begin
            grp_d   = '0;
            k_d     = '0;
            cur_d   = SlotW'(cnt_d - CntW'(1));
            state_d = (cnt_d != '0) ? StFetch : StIdle;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
        StFetch: begin
          k_d     = '0;
          state_d = StDraw;
        end
        StDraw: begin
          buf_we = (pix_code != 2'b00) && (pix_x < 9'(LINE_W));
          k_d    = k_q + 2'd1;
          if (k_q == 2'd3) begin
            grp_d   = grp_q + 2'd1;
            state_d = StFetch;
            if (grp_q == 2'd3) begin
              if (cur_q == '0) state_d = StIdle;
              else cur_d = cur_q - SlotW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      cnt_q   <= '0;
      cur_q   <= '0;
      grp_q   <= '0;
      k_q     <= '0;
      ovf_q   <= 1'b0;
      late_q  <= 1'b0;
      row_q   <= '0;
      for (int i = 0; i < MAX_PER_LINE; i++) slot_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      cur_q   <= cur_d;
      grp_q   <= grp_d;
      k_q     <= k_d;
      ovf_q   <= ovf_d;
      late_q  <= late_d;
      row_q   <= row_d;
      if (slot_we) slot_q[SlotW'(cnt_q)] <= scan_slot;
    end
  end

  sprite_line_buffer #(
    .LINE_W(LINE_W)
  ) u_line_buffer (
    .clk  (clk),
    .rst  (rst),
    .swap (swap),
    .we   (buf_we),
    .waddr(pix_x[7:0]),
    .wdata({pix_code, cur_slot.pal}),
    .re   (disp_en),
    .raddr(col),
    .rdata(buf_rdata)
  );

  assign spr_pix   = buf_rdata[7:6];
  assign spr_pal   = buf_rdata[5:0];
  assign spr_valid = |buf_rdata[7:6];
  assign busy      = (state_q != StIdle);
  assign overflow  = ovf_q;
  assign late      = late_q;

endmodule

// File: tb/tb_sprite_line_engine.sv
// Bench for sprite_line_engine: directed scenarios plus random lines, each displayed
// line compared column by column against a per-pixel priority model.
module tb_sprite_line_engine;

  localparam int NumSpr     = 8;
  localparam int MaxPerLine = 4;
  localparam int LineW      = 224;
  localparam logic [15:0] XyBase   = 16'h5060;
  localparam logic [15:0] AttrBase = 16'h4FF0;
  localparam logic [15:0] FlipAddr = 16'h5003;

  logic        clk = 1'b0;
  logic        rst, wr_en, line_start, disp_en;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data, col, rom_data;
  logic [8:0]  next_row;
  logic [11:0] rom_addr;
  logic        spr_valid, busy, overflow, late;
  logic [1:0]  spr_pix;
  logic [5:0]  spr_pal;

  logic [7:0] rom [4096];
  int tx[NumSpr], ty[NumSpr], tnum[NumSpr], txf[NumSpr], tyf[NumSpr], tpal[NumSpr];
  int tflip;
  logic [7:0] exp_img [256], exp_next [256], obs [256];
  logic exp_ovf;
  int total = 0, bad = 0;

  sprite_line_engine #(
    .NUM_SPRITES (NumSpr),
    .MAX_PER_LINE(MaxPerLine),
    .LINE_W      (LineW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .line_start(line_start),
    .next_row  (next_row),
    .disp_en   (disp_en),
    .col       (col),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .spr_valid (spr_valid),
    .spr_pix   (spr_pix),
    .spr_pal   (spr_pal),
    .busy      (busy),
    .overflow  (overflow),
    .late      (late)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= rom[rom_addr];

  initial begin
    #5_000_000;
    $fatal(1, "FAIL watchdog timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic set_sprite(input int i, input int x, input int y, input int num,
                            input int xf, input int yf, input int pal);
    cpu_write(XyBase + 16'(2 * i), 8'(x));
    cpu_write(XyBase + 16'(2 * i + 1), 8'(y));
    cpu_write(AttrBase + 16'(2 * i), 8'(num * 4 + xf * 2 + yf));
    cpu_write(AttrBase + 16'(2 * i + 1), 8'(pal));
    tx[i] = x; ty[i] = y; tnum[i] = num; txf[i] = xf; tyf[i] = yf; tpal[i] = pal;
  endtask

  task automatic set_flip(input int f);
    cpu_write(FlipAddr, 8'(f));
    tflip = f;
  endtask

  task automatic park_all();
    for (int i = 0; i < NumSpr; i++) set_sprite(i, 0, 200, 0, 0, 0, 0);
  endtask

  task automatic fill_rom(input bit rnd, input logic [7:0] v);
    for (int a = 0; a < 4096; a++) rom[a] = rnd ? 8'($urandom) : v;
  endtask

  // Per pixel: the lowest-indexed accepted sprite with an opaque pixel there wins.
  task automatic model_line(input int row);
    int hit_idx[$];
    int d, c, cc, pr, s, code, n;
    logic [7:0] b;
    for (int i = 0; i < NumSpr; i++) begin
      d = (row - ty[i]) & 255;
      if (d < 16) hit_idx.push_back(i);
    end
    exp_ovf = (hit_idx.size() > MaxPerLine);
    n = (hit_idx.size() > MaxPerLine) ? MaxPerLine : hit_idx.size();
    for (int x = 0; x < 256; x++) begin
      exp_next[x] = 8'h00;
      if (x < LineW) begin
        for (int j = 0; j < n; j++) begin
          s = hit_idx[j];
          c = x - tx[s];
          if (c >= 0 && c < 16 && exp_next[x] == 8'h00) begin
            cc = ((txf[s] ^ tflip) != 0) ? 15 - c : c;
            d = (row - ty[s]) & 255;
            pr = ((tyf[s] ^ tflip) != 0) ? 15 - d : d;
            b = rom[tnum[s] * 64 + pr * 4 + cc / 4];
            code = (int'(b) >> (2 * (cc % 4))) & 3;
            if (code != 0) exp_next[x] = 8'(code * 64 + tpal[s]);
          end
        end
      end
    end
  endtask

  task automatic pulse_start(input int row, input logic want_late);
    @(negedge clk);
    line_start = 1'b1;
    next_row = {1'($urandom), 8'(row)};
    @(posedge clk); #1;
    line_start = 1'b0;
    check("busy_rise", 32'(busy), 32'(1));
    check("late", 32'(late), 32'(want_late));
  endtask

  task automatic display(input bit chk);
    for (int c = 0; c < 256; c++) begin
      @(negedge clk);
      disp_en = 1'b1; col = 8'(c);
      @(posedge clk); #1;
      obs[c] = {spr_pix, spr_pal};
      if (chk) check($sformatf("pix[%0d]", c), 32'({spr_valid, spr_pix, spr_pal}),
                     32'({exp_img[c][7:6] != 2'b00, exp_img[c]}));
    end
    @(negedge clk);
    disp_en = 1'b0;
    @(posedge clk); #1;
    if (chk) check("pix_off", 32'({spr_valid, spr_pix, spr_pal}), 32'(0));
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy === 1'b1 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    check("busy_fall", 32'(busy), 32'(0));
  endtask

  // Shows the previously rendered line while rendering `row` into the back buffer.
  task automatic do_line(input int row);
    pulse_start(row, 1'b0);
    model_line(row);
    display(1'b1);
    wait_idle();
    check("overflow", 32'(overflow), 32'(exp_ovf));
    exp_img = exp_next;
  endtask

  task automatic clear_shadow();
    for (int i = 0; i < NumSpr; i++) begin
      tx[i] = 0; ty[i] = 0; tnum[i] = 0; txf[i] = 0; tyf[i] = 0; tpal[i] = 0;
    end
    tflip = 0;
    for (int x = 0; x < 256; x++) exp_img[x] = 8'h00;
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    line_start = 1'b0; next_row = '0; disp_en = 1'b0; col = '0;
    fill_rom(1'b0, 8'h00);
    clear_shadow();
    #12;
    check("rst_pix", 32'({spr_valid, spr_pix, spr_pal}), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_ovf", 32'(overflow), 32'(0));
    check("rst_late", 32'(late), 32'(0));
    check("rst_rom_addr", 32'(rom_addr), 32'(0));
    @(negedge clk);
    rst = 1'b0;

    // Single sprite
    park_all();
    fill_rom(1'b0, 8'h55);
    set_sprite(0, 10, 20, 3, 0, 0, 5);
    do_line(25);
    do_line(250);
    check("single_c9", 32'(obs[9]), 32'(8'h00));
    check("single_c10", 32'(obs[10]), 32'(8'h45));
    check("single_c25", 32'(obs[25]), 32'(8'h45));
    check("single_c26", 32'(obs[26]), 32'(8'h00));

    // Priority overlap
    set_sprite(1, 10, 20, 3, 0, 0, 7);
    set_sprite(0, 10, 20, 3, 0, 0, 2);
    do_line(25);
    do_line(250);
    check("prio_c10", 32'(obs[10]), 32'(8'h42));
    check("prio_c18", 32'(obs[18]), 32'(8'h42));
    check("prio_c25", 32'(obs[25]), 32'(8'h42));
    set_sprite(1, 0, 200, 0, 0, 0, 0);

    // xflip, then xflip cancelled by screen flip
    fill_rom(1'b0, 8'h00);
    for (int p = 0; p < 16; p++) rom[3 * 64 + p * 4] = 8'h03;
    set_sprite(0, 50, 20, 3, 1, 0, 9);
    do_line(25);
    do_line(250);
    check("xflip_c65", 32'(obs[65]), 32'(8'hC9));
    check("xflip_c50", 32'(obs[50]), 32'(8'h00));
    set_flip(1);
    do_line(25);
    do_line(250);
    check("sflip_c50", 32'(obs[50]), 32'(8'hC9));
    check("sflip_c65", 32'(obs[65]), 32'(8'h00));
    set_flip(0);

    // Overflow: five sprites on one row with four slots
    fill_rom(1'b0, 8'h55);
    for (int i = 0; i < 4; i++) set_sprite(i, 20 * i, 30 + i, i + 1, 0, 0, 10 + i);
    set_sprite(4, 150, 35, 5, 0, 0, 20);
    cpu_write(16'h5070, 8'hAA);
    cpu_write(16'h4FEF, 8'hAA);
    do_line(40);
    check("ovf_set", 32'(overflow), 32'(1));
    park_all();
    do_line(250);
    check("ovf_clr", 32'(overflow), 32'(0));
    check("ovf_drop150", 32'(obs[150]), 32'(8'h00));
    check("ovf_drop158", 32'(obs[158]), 32'(8'h00));

    // Right-edge clip
    set_sprite(0, 220, 20, 3, 0, 0, 5);
    do_line(25);
    do_line(250);
    check("edge_c220", 32'(obs[220]), 32'(8'h45));
    check("edge_c223", 32'(obs[223]), 32'(8'h45));
    check("edge_c0", 32'(obs[0]), 32'(8'h00));
    check("edge_c11", 32'(obs[11]), 32'(8'h00));

    // Late line_start during a four-slot render
    fill_rom(1'b1, 8'h00);
    for (int i = 0; i < 6; i++) set_sprite(i, 30 * i, 50 + i, 10 + i, i % 2, i / 3, 30 + i);
    pulse_start(60, 1'b0);
    model_line(60);
    repeat (49) @(posedge clk);
    #1 check("late_busy_pre", 32'(busy), 32'(1));
    pulse_start(60, 1'b1);
    @(posedge clk); #1;
    check("late_pulse_end", 32'(late), 32'(0));
    check("late_busy_hold", 32'(busy), 32'(1));
    display(1'b0);
    wait_idle();
    check("late_ovf", 32'(overflow), 32'(exp_ovf));
    exp_img = exp_next;
    do_line(250);

    // Random lines against the model
    for (int t = 0; t < 6; t++) begin
      int row;
      row = $urandom_range(0, 255);
      set_flip($urandom_range(0, 1));
      for (int i = 0; i < NumSpr; i++)
        set_sprite(i, $urandom_range(0, 255), (row - $urandom_range(0, 20)) & 255,
                   $urandom_range(0, 63), $urandom_range(0, 1), $urandom_range(0, 1),
                   $urandom_range(0, 63));
      cpu_write(16'h5002, 8'hFF);
      do_line(row);
    end
    set_flip(0);
    park_all();
    do_line(250);

    // Reset in the middle of a render
    for (int i = 0; i < 6; i++) set_sprite(i, 25 * i, 100, i, 0, 0, i + 1);
    pulse_start(105, 1'b0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy), 32'(0));
    check("mid_rst_pix", 32'({spr_valid, spr_pix, spr_pal}), 32'(0));
    check("mid_rst_rom", 32'(rom_addr), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    clear_shadow();
    do_line(100);
    do_line(5);
    do_line(250);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
